// File: rtl/cs_pkg.sv
// Shared definitions for the control-store override pipe: prefix byte codes,
// segment and size encodings, and the prefix accumulator record.
package cs_pkg;

   localparam logic [7:0] PREF_REPNE = 8'hF2;
   localparam logic [7:0] PREF_REP   = 8'hF3;
   localparam logic [7:0] PREF_OPSZ  = 8'h66;
   localparam logic [7:0] PREF_ES    = 8'h26;
   localparam logic [7:0] PREF_CS    = 8'h2E;
   localparam logic [7:0] PREF_SS    = 8'h36;
   localparam logic [7:0] PREF_DS    = 8'h3E;
   localparam logic [7:0] PREF_FS    = 8'h64;
   localparam logic [7:0] PREF_GS    = 8'h65;

   typedef enum logic [2:0] {
      SEG_ES = 3'd0,
      SEG_CS = 3'd1,
      SEG_SS = 3'd2,
      SEG_DS = 3'd3,
      SEG_FS = 3'd4,
      SEG_GS = 3'd5
   } seg_e;

   localparam logic [1:0] SZ_16 = 2'b01;
   localparam logic [1:0] SZ_32 = 2'b10;

   // Wide enough for any MAX_PREF up to 15.
   localparam int ACC_CNT_W = 4;

   typedef struct packed {
      logic                 rep;
      logic                 size;
      logic                 seg_ovr;
      seg_e                 seg_code;
      logic [ACC_CNT_W-1:0] count;
   } pref_acc_t;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_PENDING = 1'b1
   } acc_state_e;

endpackage

// File: rtl/cs_prefix_acc.sv
// Prefix decoder and accumulator: gathers REP/operand-size/segment prefixes
// for the next instruction and flags a sticky overflow past MAX_PREF.
module cs_prefix_acc
   import cs_pkg::*;
#(
   parameter int MAX_PREF = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_pref_valid,
   input  logic [7:0] i_pref_byte,
   input  logic       i_clr,
   output pref_acc_t  o_acc,
   output logic       o_pref_err
);

   localparam logic [ACC_CNT_W-1:0] CNT_MAX = ACC_CNT_W'(MAX_PREF);

   pref_acc_t  r_acc;
   logic       r_err;
   acc_state_e r_state;

   pref_acc_t  w_base;
   pref_acc_t  w_next;
   logic       w_err_nxt;
   logic       w_hit;
   logic       w_is_rep;
   logic       w_is_sz;
   logic       w_is_seg;
   seg_e       w_seg_code;
   acc_state_e w_state_nxt;

   always_comb begin
      w_is_rep   = 1'b0;
      w_is_sz    = 1'b0;
      w_is_seg   = 1'b0;
      w_seg_code = SEG_ES;
      if (i_pref_valid) begin
         case (i_pref_byte)
            PREF_REP, PREF_REPNE: w_is_rep = 1'b1;
            PREF_OPSZ:            w_is_sz  = 1'b1;
            PREF_ES: begin w_is_seg = 1'b1; w_seg_code = SEG_ES; end
            PREF_CS: begin w_is_seg = 1'b1; w_seg_code = SEG_CS; end
            PREF_SS: begin w_is_seg = 1'b1; w_seg_code = SEG_SS; end
            PREF_DS: begin w_is_seg = 1'b1; w_seg_code = SEG_DS; end
            PREF_FS: begin w_is_seg = 1'b1; w_seg_code = SEG_FS; end
            PREF_GS: begin w_is_seg = 1'b1; w_seg_code = SEG_GS; end
            default: ;
         endcase
      end
      w_hit = w_is_rep || w_is_sz || w_is_seg;

      // A prefix arriving with an accept starts the next instruction's record.
      w_base    = i_clr ? pref_acc_t'('0) : r_acc;
      w_next    = w_base;
      w_err_nxt = r_err;
      if (w_hit) begin
         if (w_base.count == CNT_MAX) begin
            w_err_nxt = 1'b1;
         end else begin
            if (w_is_rep) w_next.rep  = 1'b1;
            if (w_is_sz)  w_next.size = 1'b1;
            if (w_is_seg) begin
               w_next.seg_ovr  = 1'b1;
               w_next.seg_code = w_seg_code;
            end
            w_next.count = w_base.count + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_COLLECT: if (r_acc.count != '0) w_state_nxt = ST_PENDING;
         ST_PENDING: if (i_clr)             w_state_nxt = ST_COLLECT;
         default:                           w_state_nxt = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc   <= '0;
         r_err   <= 1'b0;
         r_state <= ST_COLLECT;
      end else begin
         r_acc   <= w_next;
         r_err   <= w_err_nxt;
         r_state <= w_state_nxt;
      end
   end

   assign o_acc      = r_acc;
   assign o_pref_err = r_err;

endmodule

// File: rtl/cs_override_pipe.sv
// Decode-stage control-store override: applies accumulated prefixes and ModRM
// fields to the accepted bundle and holds it in a one-entry valid/ready register.
module cs_override_pipe
   import cs_pkg::*;
#(
   parameter int CW_W     = 230,
   parameter int NUM_RCH  = 2,
   parameter int MAX_PREF = 4,
   parameter int SEG_W    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pref_valid,
   input  logic [7:0]           pref_byte,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CW_W-1:0]      cw_in,
   input  logic [NUM_RCH-1:0]   rch_ovr_en,
   input  logic [3*NUM_RCH-1:0] rch_in,
   input  logic                 is_mod,
   input  logic                 is_double,
   input  logic [7:0]           b2,
   input  logic [7:0]           b3,
   input  logic [1:0]           size_in,
   input  logic [1:0]           imm_size_in,
   input  logic [SEG_W-1:0]     seg_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CW_W-1:0]      cw_out,
   output logic [3*NUM_RCH-1:0] rch_out,
   output logic [1:0]           size_out,
   output logic [1:0]           imm_size_out,
   output logic [SEG_W-1:0]     seg_out,
   output logic                 is_rep_out,
   output logic                 pref_err
);

   pref_acc_t            w_acc;
   logic                 w_accept;
   logic [7:0]           w_m;
   logic                 w_is_reg;
   logic                 w_sz_fire;
   logic [1:0]           w_size;
   logic [1:0]           w_imm;
   logic [SEG_W-1:0]     w_seg;
   logic [3*NUM_RCH-1:0] w_rch;

   logic                 r_vld_p1;
   logic [CW_W-1:0]      r_cw_p1;
   logic [3*NUM_RCH-1:0] r_rch_p1;
   logic [1:0]           r_size_p1;
   logic [1:0]           r_imm_p1;
   logic [SEG_W-1:0]     r_seg_p1;
   logic                 r_rep_p1;

   assign in_ready = !r_vld_p1 || out_ready;
   assign w_accept = in_valid && in_ready;

   cs_prefix_acc #(
      .MAX_PREF (MAX_PREF)
   ) u_prefix_acc (
      .clk          (clk),
      .rst          (rst),
      .i_pref_valid (pref_valid),
      .i_pref_byte  (pref_byte),
      .i_clr        (w_accept),
      .o_acc        (w_acc),
      .o_pref_err   (pref_err)
   );

   // Stage 0: override mux on the bundle using the prefixes gathered so far.
   always_comb begin
      w_m       = is_double ? b3 : b2;
      w_is_reg  = (w_m[7:6] == 2'b11);
      w_sz_fire = w_acc.size && (size_in == SZ_32);
      w_size    = w_sz_fire ? SZ_16 : size_in;
      w_imm     = (w_sz_fire && (imm_size_in != 2'b00)) ? SZ_16 : imm_size_in;
      w_seg     = (w_acc.seg_ovr && is_mod) ? SEG_W'(w_acc.seg_code) : seg_in;
      w_rch     = rch_in;
      for (int k = 0; k < NUM_RCH; k++) begin
         if ((k % 2) == 0) begin
            if (is_mod && rch_ovr_en[k]) w_rch[3*k +: 3] = w_m[5:3];
         end else begin
            if (is_mod && rch_ovr_en[k] && w_is_reg) w_rch[3*k +: 3] = w_m[2:0];
         end
      end
   end

   // Stage 1: one-entry output register; an accept during drain simply reloads it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p1  <= 1'b0;
         r_cw_p1   <= '0;
         r_rch_p1  <= '0;
         r_size_p1 <= '0;
         r_imm_p1  <= '0;
         r_seg_p1  <= '0;
         r_rep_p1  <= 1'b0;
      end else if (w_accept) begin
         r_vld_p1  <= 1'b1;
         r_cw_p1   <= cw_in;
         r_rch_p1  <= w_rch;
         r_size_p1 <= w_size;
         r_imm_p1  <= w_imm;
         r_seg_p1  <= w_seg;
         r_rep_p1  <= w_acc.rep;
      end else if (out_ready) begin
         r_vld_p1  <= 1'b0;
      end
   end

   assign out_valid    = r_vld_p1;
   assign cw_out       = r_cw_p1;
   assign rch_out      = r_rch_p1;
   assign size_out     = r_size_p1;
   assign imm_size_out = r_imm_p1;
   assign seg_out      = r_seg_p1;
   assign is_rep_out   = r_rep_p1;

endmodule
